// File: rtl/highpass_switch_ctrl.sv
// Click-free filter change sequencer for the highpass biquad: fade out, clear history, switch, fade in.
// Define HPF_CLICK_FADE_EN to build the gain ramps; without it the sequence is IDLE->CLEAR->SWITCH->IDLE.
module highpass_switch_ctrl #(
  parameter int RAMP_LOG2     = 6,
  parameter int CLEAR_SAMPLES = 2,
  parameter int NUM_FILTERS   = 5
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [2:0]         filter_req,
  input  logic signed [15:0] audioIn,
  output logic signed [15:0] audioOut,
  output logic [2:0]         filter,
  output logic               state_clear,
  output logic               busy,
  output logic               ack
);
  // state    | meaning
  // IDLE     | full gain, watching for a changed request
  // FADE_OUT | gain steps down once per tick
  // CLEAR    | biquad history held at zero, output muted
  // SWITCH   | single clock: apply target code, pulse ack
  // FADE_IN  | gain steps up once per tick
  typedef enum logic [2:0] {IDLE, FADE_OUT, CLEAR, SWITCH, FADE_IN} state_t;

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = 16 + RAMP_LOG2 + 2;
  localparam int CW = $clog2(CLEAR_SAMPLES + 1);
  localparam logic [GW-1:0] G_FULL   = GW'(1) << RAMP_LOG2;
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_SAMPLES - 1);
  localparam int unsigned   NF       = NUM_FILTERS;

  state_t               state, state_next;
  logic [2:0]           target, req_mapped;
  logic [CW-1:0]        clr_cnt;
  logic [GW-1:0]        g_new;
  logic signed [PW-1:0] product;

  // Out-of-range codes fall back to the bypass filter.
  assign req_mapped = (32'(filter_req) >= NF) ? 3'd0 : filter_req;

`ifdef HPF_CLICK_FADE_EN
  logic [GW-1:0] g;

  always_comb begin
    g_new = g;
    if (state == FADE_OUT)
      g_new = g - GW'(1);
    else if (state == FADE_IN)
      g_new = g + GW'(1);
  end

  always_ff @(posedge clk_48) begin
    if (reset)
      g <= G_FULL;
    else if (sample_tick)
      g <= g_new;
  end
`else
  assign g_new = G_FULL;
`endif

  assign product = PW'(audioIn) * PW'($signed({1'b0, g_new}));

  always_ff @(posedge clk_48) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (sample_tick && (req_mapped != filter))
`ifdef HPF_CLICK_FADE_EN
          state_next = FADE_OUT;
`else
          state_next = CLEAR;
`endif
`ifdef HPF_CLICK_FADE_EN
      FADE_OUT:
        if (sample_tick && (g_new == '0))
          state_next = CLEAR;
      FADE_IN:
        if (sample_tick && (g_new == G_FULL))
          state_next = IDLE;
`endif
      CLEAR:
        if (sample_tick && (clr_cnt == '0))
          state_next = SWITCH;
      SWITCH:
`ifdef HPF_CLICK_FADE_EN
        state_next = FADE_IN;
`else
        state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    ack         = (state == SWITCH);
    state_clear = (state == CLEAR);
  end

  // clr_cnt is a down-counter of remaining CLEAR ticks, loaded on entry.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      target   <= 3'd0;
      filter   <= 3'd0;
      clr_cnt  <= '0;
      audioOut <= '0;
    end else begin
      if (sample_tick && (state != SWITCH))
        target <= req_mapped;
      if (state == SWITCH)
        filter <= target;
      if ((state != CLEAR) && (state_next == CLEAR))
        clr_cnt <= CLR_LOAD;
      else if ((state == CLEAR) && sample_tick && (clr_cnt != '0))
        clr_cnt <= clr_cnt - CW'(1);
      if (sample_tick)
        audioOut <= (state == CLEAR) ? '0 : 16'(product >>> RAMP_LOG2);
    end
  end

endmodule

// File: tb/tb_highpass_switch_ctrl.sv
// Scoreboard bench for highpass_switch_ctrl; follows HPF_CLICK_FADE_EN to pick the fade or no-fade scenarios.
`timescale 1ns/1ps
module tb_highpass_switch_ctrl;
  localparam int RL   = 6;
  localparam int FULL = 64;

  logic               clk_48 = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic [2:0]         filter_req;
  logic signed [15:0] audioIn;
  logic signed [15:0] audioOut;
  logic [2:0]         filter;
  logic               state_clear;
  logic               busy;
  logic               ack;

  always #5 clk_48 = ~clk_48;

  highpass_switch_ctrl dut (
    .clk_48      (clk_48),
    .reset       (reset),
    .sample_tick (sample_tick),
    .filter_req  (filter_req),
    .audioIn     (audioIn),
    .audioOut    (audioOut),
    .filter      (filter),
    .state_clear (state_clear),
    .busy        (busy),
    .ack         (ack)
  );

  typedef struct {
    string              nm;
    logic signed [15:0] aout;
    logic               clr;
    logic [2:0]         filt;
    logic               bsy;
    int                 acks;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   ack_cnt  = 0;
  int   exp_acks = 0;

  always @(negedge clk_48) if (ack === 1'b1) ack_cnt++;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic logic signed [15:0] fl(input logic signed [15:0] a, input int g);
    int p;
    p = int'(a) * g;
    return 16'(p >>> RL);
  endfunction

  // Issue one sample tick and push the response expected three clocks later.
  task automatic tick(input string nm, input logic signed [15:0] ain, input logic [2:0] req,
                      input logic signed [15:0] e_out, input logic e_clr, input logic [2:0] e_filt,
                      input logic e_busy);
    exp_t e;
    e.nm = nm; e.aout = e_out; e.clr = e_clr; e.filt = e_filt; e.bsy = e_busy; e.acks = exp_acks;
    exp_q.push_back(e);
    audioIn     = ain;
    filter_req  = req;
    sample_tick = 1'b1;
    @(negedge clk_48);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk_48);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_48);
      if (sample_tick === 1'b1 && reset === 1'b0) begin
        repeat (3) @(negedge clk_48);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_underflow: got output with no expectation queued, required 1");
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, ".audioOut"},    audioOut,    e.aout);
          chk({e.nm, ".state_clear"}, state_clear, 32'(e.clr));
          chk({e.nm, ".filter"},      filter,      32'(e.filt));
          chk({e.nm, ".busy"},        busy,        32'(e.bsy));
          chk({e.nm, ".acks"},        ack_cnt,     e.acks);
        end
      end
    end
  end

  task automatic reset_check(input string nm);
    reset       = 1'b1;
    sample_tick = 1'b0;
    filter_req  = 3'd0;
    @(negedge clk_48);
    chk({nm, ".audioOut"},    audioOut,    0);
    chk({nm, ".filter"},      filter,      0);
    chk({nm, ".busy"},        busy,        0);
    chk({nm, ".state_clear"}, state_clear, 0);
    chk({nm, ".ack"},         ack,         0);
    reset = 1'b0;
    repeat (3) @(negedge clk_48);
    chk({nm, ".acks_after"}, ack_cnt, exp_acks);
    chk({nm, ".busy_after"}, busy,    0);
  endtask

`ifdef HPF_CLICK_FADE_EN
  task automatic fade_seq(input string nm, input logic signed [15:0] ain,
                          input logic signed [15:0] ain1, input logic signed [15:0] e1,
                          input logic [2:0] req_a, input logic [2:0] req_b, input int change_at,
                          input logic [2:0] f_old, input logic [2:0] f_new);
    logic [2:0] rq;
    tick({nm, ".detect"}, ain, req_a, ain, 1'b0, f_old, 1'b1);
    for (int i = 1; i <= FULL; i++) begin
      rq = (i >= change_at) ? req_b : req_a;
      if (i == 1)
        tick($sformatf("%s.fo%0d", nm, i), ain1, rq, e1, 1'b0, f_old, 1'b1);
      else
        tick($sformatf("%s.fo%0d", nm, i), ain, rq, fl(ain, FULL - i), (i == FULL), f_old, 1'b1);
    end
    tick({nm, ".clr1"}, ain, req_b, 16'sd0, 1'b1, f_old, 1'b1);
    exp_acks++;
    tick({nm, ".clr2"}, ain, req_b, 16'sd0, 1'b0, f_new, 1'b1);
    for (int j = 1; j <= FULL; j++)
      tick($sformatf("%s.fi%0d", nm, j), ain, req_b, fl(ain, j), 1'b0, f_new, (j != FULL));
    tick({nm, ".idle"}, ain, req_b, ain, 1'b0, f_new, 1'b0);
  endtask
`else
  task automatic clr_seq(input string nm, input logic signed [15:0] ain,
                         input logic [2:0] req_a, input logic [2:0] req_b,
                         input logic [2:0] f_old, input logic [2:0] f_new);
    tick({nm, ".detect"}, ain, req_a, ain, 1'b1, f_old, 1'b1);
    tick({nm, ".clr1"}, ain, req_b, 16'sd0, 1'b1, f_old, 1'b1);
    exp_acks++;
    tick({nm, ".clr2"}, ain, req_b, 16'sd0, 1'b0, f_new, 1'b0);
    tick({nm, ".idle"}, ain, req_b, ain, 1'b0, f_new, 1'b0);
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset       = 1'b1;
    sample_tick = 1'b0;
    filter_req  = 3'd0;
    audioIn     = 16'sd0;
    repeat (3) @(negedge clk_48);
    reset_check("por");

`ifdef HPF_CLICK_FADE_EN
    tick("idle0", 16'sd1000, 3'd0, 16'sd1000, 1'b0, 3'd0, 1'b0);
    fade_seq("ramp03", 16'sd1000, -16'sd1000, -16'sd985, 3'd3, 3'd3, 1, 3'd0, 3'd3);
    tick("abort.detect", 16'sd1000, 3'd1, 16'sd1000, 1'b0, 3'd3, 1'b1);
    for (int i = 1; i <= 5; i++)
      tick($sformatf("abort.fo%0d", i), 16'sd1000, 3'd1, fl(16'sd1000, FULL - i), 1'b0, 3'd3, 1'b1);
    reset_check("abort_rst");
    tick("req7_f0", 16'sd1000, 3'd7, 16'sd1000, 1'b0, 3'd0, 1'b0);
    tick("req5_f0", 16'sd1000, 3'd5, 16'sd1000, 1'b0, 3'd0, 1'b0);
    fade_seq("latest", 16'sd1000, 16'sd1000, 16'sd984, 3'd1, 3'd4, 10, 3'd0, 3'd4);
    fade_seq("neg42", -16'sd500, -16'sd500, -16'sd493, 3'd2, 3'd2, 1, 3'd4, 3'd2);
    fade_seq("map7", 16'sd700, 16'sd700, 16'sd689, 3'd7, 3'd7, 1, 3'd2, 3'd0);
`else
    tick("idle0", 16'sd1000, 3'd0, 16'sd1000, 1'b0, 3'd0, 1'b0);
    tick("req7_f0", 16'sd1000, 3'd7, 16'sd1000, 1'b0, 3'd0, 1'b0);
    tick("req5_f0", -16'sd42, 3'd5, -16'sd42, 1'b0, 3'd0, 1'b0);
    clr_seq("sw02", 16'sd300, 3'd2, 3'd2, 3'd0, 3'd2);
    clr_seq("latest", -16'sd1234, 3'd1, 3'd3, 3'd2, 3'd3);
    clr_seq("map7", 16'sd777, 3'd7, 3'd7, 3'd3, 3'd0);
    tick("abort.detect", 16'sd1000, 3'd4, 16'sd1000, 1'b1, 3'd0, 1'b1);
    reset_check("abort_rst");
    tick("post_rst", 16'sd1000, 3'd0, 16'sd1000, 1'b0, 3'd0, 1'b0);
    clr_seq("sw04", 16'sd32767, 3'd4, 3'd4, 3'd0, 3'd4);
`endif

    repeat (4) @(negedge clk_48);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
